// File: rtl/switchbox_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : switchbox_pkg
//  Description : Shared constants and elaboration-time helpers for the
//                parametrised Wilton switch box: select widths, total
//                configuration length, field offsets and Wilton source map.
//  Revision    : 1.0 - initial release
// ============================================================================
package switchbox_pkg;

    // Side numbering used for configuration fields and output ordering.
    localparam int c_side_north = 0;
    localparam int c_side_east  = 1;
    localparam int c_side_south = 2;
    localparam int c_side_west  = 3;

    // Width of one track-mux select: L LE outputs plus three Wilton sources.
    function automatic int sb_sel_bits(input int l);
        return $clog2(3 + l);
    endfunction

    // Width of one LE-input select: all 4W incoming tracks plus L LE outputs.
    function automatic int le_sel_bits(input int w, input int l);
        return $clog2(4 * w + l);
    endfunction

    // Total chain length; bypass bits only exist with the output registers.
    function automatic int cfg_bits(input int w, input int l, input int i, input bit reg_en);
        int total;
        total = 4 * w * sb_sel_bits(l) + l * i * le_sel_bits(w, l);
        if (reg_en)
            total = total + 4 * w;
        return total;
    endfunction

    // LSB of the select field for output track trk on a side.
    function automatic int track_off(input int side, input int trk, input int w, input int l);
        return (side * w + trk) * sb_sel_bits(l);
    endfunction

    // LSB of the select field for input j of LE k.
    function automatic int le_off(input int k, input int j, input int w, input int l, input int i);
        return 4 * w * sb_sel_bits(l) + (k * i + j) * le_sel_bits(w, l);
    endfunction

    // Position of the bypass bit of output track trk on a side.
    function automatic int byp_off(input int side, input int trk, input int w, input int l, input int i);
        return 4 * w * sb_sel_bits(l) + l * i * le_sel_bits(w, l) + side * w + trk;
    endfunction

    // Base of a side inside the flat incoming-track vector {north,east,south,west}.
    function automatic int flat_base(input int side, input int w);
        int base;
        case (side)
            c_side_west:  base = 0;
            c_side_south: base = w;
            c_side_east:  base = 2 * w;
            default:      base = 3 * w;
        endcase
        return base;
    endfunction

    // Flat incoming-track index of Wilton source k (0..2) for output track trk.
    function automatic int wilton_src(input int side, input int k, input int trk, input int w);
        int idx;
        case (side)
            c_side_north: begin
                if (k == 0)      idx = flat_base(c_side_east, w)  + (w - trk) % w;
                else if (k == 1) idx = flat_base(c_side_south, w) + trk;
                else             idx = flat_base(c_side_west, w)  + (trk + 1) % w;
            end
            c_side_east: begin
                if (k == 0)      idx = flat_base(c_side_south, w) + (trk + 1) % w;
                else if (k == 1) idx = flat_base(c_side_west, w)  + trk;
                else             idx = flat_base(c_side_north, w) + (w - trk) % w;
            end
            c_side_south: begin
                if (k == 0)      idx = flat_base(c_side_west, w)  + (2 * w - 2 - trk) % w;
                else if (k == 1) idx = flat_base(c_side_north, w) + trk;
                else             idx = flat_base(c_side_east, w)  + (trk + 1) % w;
            end
            default: begin
                if (k == 0)      idx = flat_base(c_side_north, w) + (trk + 1) % w;
                else if (k == 1) idx = flat_base(c_side_east, w)  + trk;
                else             idx = flat_base(c_side_south, w) + (2 * w - 2 - trk) % w;
            end
        endcase
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/switchbox_mux.sv
`default_nettype none
// ============================================================================
//  Module      : switchbox_mux
//  Description : N-input single-bit mux; any select value >= N yields 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module switchbox_mux #(
    parameter int N     = 4,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     data_in,
    input  logic [SEL_W-1:0] sel,
    output logic             data_out
);

    // Decode the select; unmatched (out-of-range) codes fall through to 0.
    always_comb begin
        data_out = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (sel == SEL_W'(k))
                data_out = data_in[k];
        end
    end

endmodule
`default_nettype wire

// File: rtl/switchbox_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : switchbox_cfg
//  Description : Parametrised Wilton switch box with a serial shadow/active
//                configuration chain. Optional per-track output registers
//                with bypass bits are enabled by SWITCHBOX_OUTPUT_REG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module switchbox_cfg
    import switchbox_pkg::*;
#(
    parameter int CHANNEL_WIDTH = 6,
    parameter int LE_COUNT      = 2,
    parameter int LE_INPUTS     = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [CHANNEL_WIDTH-1:0]      data_north_in,
    input  logic [CHANNEL_WIDTH-1:0]      data_east_in,
    input  logic [CHANNEL_WIDTH-1:0]      data_south_in,
    input  logic [CHANNEL_WIDTH-1:0]      data_west_in,
    output logic [CHANNEL_WIDTH-1:0]      data_north_out,
    output logic [CHANNEL_WIDTH-1:0]      data_east_out,
    output logic [CHANNEL_WIDTH-1:0]      data_south_out,
    output logic [CHANNEL_WIDTH-1:0]      data_west_out,
    input  logic [LE_COUNT-1:0]           data_from_les,
    output logic [LE_COUNT*LE_INPUTS-1:0] data_to_les,
    input  logic                          config_in,
    input  logic                          config_valid,
    input  logic                          config_commit,
    output logic                          config_out,
    output logic                          config_loaded
);

    localparam int c_w = CHANNEL_WIDTH;
    localparam int c_l = LE_COUNT;
    localparam int c_i = LE_INPUTS;
`ifdef SWITCHBOX_OUTPUT_REG_EN
    localparam bit c_reg_en = 1'b1;
`else
    localparam bit c_reg_en = 1'b0;
`endif
    localparam int c_sb_sel   = sb_sel_bits(c_l);
    localparam int c_le_sel   = le_sel_bits(c_w, c_l);
    localparam int c_cfg_bits = cfg_bits(c_w, c_l, c_i, c_reg_en);

    logic [c_cfg_bits-1:0] r_shadow;
    logic [c_cfg_bits-1:0] r_active;
    logic                  r_loaded;

    // Flat incoming tracks: west at the LSB, then south, east, north.
    logic [4*c_w-1:0]     w_tracks_in;
    // Side outputs indexed side*W+track in north, east, south, west order.
    logic [4*c_w-1:0]     w_side_mux;
    logic [4*c_w-1:0]     w_side_out;
    logic [c_l*c_i-1:0]   w_le_mux;

    assign w_tracks_in = {data_north_in, data_east_in, data_south_in, data_west_in};

    // Shadow shift register and shadow-to-active commit; commit takes the pre-shift shadow.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shadow <= '0;
            r_active <= '0;
            r_loaded <= 1'b0;
        end else begin
            if (config_valid)
                r_shadow <= {r_shadow[c_cfg_bits-2:0], config_in};
            if (config_commit) begin
                r_active <= r_shadow;
                r_loaded <= 1'b1;
            end
        end
    end

    assign config_out    = r_shadow[c_cfg_bits-1];
    assign config_loaded = r_loaded;

    generate
        for (genvar s = 0; s < 4; s++) begin : g_side
            for (genvar t = 0; t < c_w; t++) begin : g_trk
                localparam int c_idx = s * c_w + t;
                localparam int c_off = track_off(s, t, c_w, c_l);
                logic [c_l+2:0] w_src;

                assign w_src = {w_tracks_in[wilton_src(s, 2, t, c_w)],
                                w_tracks_in[wilton_src(s, 1, t, c_w)],
                                w_tracks_in[wilton_src(s, 0, t, c_w)],
                                data_from_les};

                switchbox_mux #(
                    .N     (c_l + 3),
                    .SEL_W (c_sb_sel)
                ) u_track_mux (
                    .data_in  (w_src),
                    .sel      (r_active[c_off +: c_sb_sel]),
                    .data_out (w_side_mux[c_idx])
                );

`ifdef SWITCHBOX_OUTPUT_REG_EN
                logic r_q;

                // Optional one-cycle output stage for this track.
                always_ff @(posedge clock) begin
                    if (reset)
                        r_q <= 1'b0;
                    else
                        r_q <= w_side_mux[c_idx];
                end

                assign w_side_out[c_idx] = r_active[byp_off(s, t, c_w, c_l, c_i)] ? r_q
                                                                                  : w_side_mux[c_idx];
`else
                assign w_side_out[c_idx] = w_side_mux[c_idx];
`endif
            end
        end

        for (genvar k = 0; k < c_l; k++) begin : g_le
            for (genvar j = 0; j < c_i; j++) begin : g_in
                localparam int c_off = le_off(k, j, c_w, c_l, c_i);

                switchbox_mux #(
                    .N     (4 * c_w + c_l),
                    .SEL_W (c_le_sel)
                ) u_le_mux (
                    .data_in  ({w_tracks_in, data_from_les}),
                    .sel      (r_active[c_off +: c_le_sel]),
                    .data_out (w_le_mux[k*c_i+j])
                );
            end
        end
    endgenerate

    // A cleared configuration could form loops, so everything is held low until the first commit.
    assign data_north_out = r_loaded ? w_side_out[c_side_north*c_w +: c_w] : '0;
    assign data_east_out  = r_loaded ? w_side_out[c_side_east*c_w  +: c_w] : '0;
    assign data_south_out = r_loaded ? w_side_out[c_side_south*c_w +: c_w] : '0;
    assign data_west_out  = r_loaded ? w_side_out[c_side_west*c_w  +: c_w] : '0;
    assign data_to_les    = r_loaded ? w_le_mux : '0;

endmodule
`default_nettype wire

// File: tb/tb_switchbox_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switchbox_cfg
//  Description : Directed, table-driven self-checking bench for switchbox_cfg
//                at W=6, L=2, I=4. Covers SWITCHBOX_OUTPUT_REG_EN when set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switchbox_cfg;

`ifdef SWITCHBOX_OUTPUT_REG_EN
    localparam int c_cfg_bits = 136;
`else
    localparam int c_cfg_bits = 112;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] data_north_in, data_east_in, data_south_in, data_west_in;
    logic [5:0] data_north_out, data_east_out, data_south_out, data_west_out;
    logic [1:0] data_from_les;
    logic [7:0] data_to_les;
    logic       config_in, config_valid, config_commit;
    logic       config_out, config_loaded;

    int errors = 0;
    int checks = 0;

    logic [c_cfg_bits-1:0] cfg;
    logic [255:0]          pat;

    typedef struct packed {
        logic [5:0]  n;
        logic [5:0]  e;
        logic [5:0]  s;
        logic [5:0]  w;
        logic [1:0]  les;
        logic [31:0] exp;   // {north_out, east_out, south_out, west_out, to_les}
    } vec_t;

    vec_t vecs [12];

    switchbox_cfg #(
        .CHANNEL_WIDTH (6),
        .LE_COUNT      (2),
        .LE_INPUTS     (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .data_north_in  (data_north_in),
        .data_east_in   (data_east_in),
        .data_south_in  (data_south_in),
        .data_west_in   (data_west_in),
        .data_north_out (data_north_out),
        .data_east_out  (data_east_out),
        .data_south_out (data_south_out),
        .data_west_out  (data_west_out),
        .data_from_les  (data_from_les),
        .data_to_les    (data_to_les),
        .config_in      (config_in),
        .config_valid   (config_valid),
        .config_commit  (config_commit),
        .config_out     (config_out),
        .config_loaded  (config_loaded)
    );

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic [5:0] n, input logic [5:0] e, input logic [5:0] s,
                                input logic [5:0] w, input logic [1:0] les, input logic [31:0] exp);
        vec_t v;
        v.n = n; v.e = e; v.s = s; v.w = w; v.les = les; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] n, input logic [5:0] e, input logic [5:0] s,
                         input logic [5:0] w, input logic [1:0] les);
        data_north_in = n; data_east_in = e; data_south_in = s; data_west_in = w;
        data_from_les = les;
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) begin
            drive(vecs[v].n, vecs[v].e, vecs[v].s, vecs[v].w, vecs[v].les);
            #2;
            check($sformatf("vec%0d", v),
                  {data_north_out, data_east_out, data_south_out, data_west_out, data_to_les},
                  vecs[v].exp);
        end
    endtask

    task automatic cfg_fill(input logic [2:0] tsel, input logic [4:0] lsel);
        cfg = '0;
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 6; i++)
                cfg[(s*6+i)*3 +: 3] = tsel;
        for (int k = 0; k < 8; k++)
            cfg[72+k*5 +: 5] = lsel;
    endtask

    task automatic set_trk(input int s, input int i, input logic [2:0] sel);
        cfg[(s*6+i)*3 +: 3] = sel;
    endtask

    task automatic set_le(input int k, input int j, input logic [4:0] sel);
        cfg[72+(k*4+j)*5 +: 5] = sel;
    endtask

    // First bit shifted ends at the MSB, so shift the MSB of cfg first.
    task automatic load_cfg();
        for (int n = c_cfg_bits - 1; n >= 0; n--) begin
            config_in    = cfg[n];
            config_valid = 1'b1;
            @(posedge clock); #1;
        end
        config_valid = 1'b0;
        config_in    = 1'b0;
    endtask

    task automatic commit();
        config_commit = 1'b1;
        @(posedge clock); #1;
        config_commit = 1'b0;
    endtask

    initial begin
        logic [2:0] nsel [6];
        logic [4:0] lsel [8];

        vecs[0]  = mk(6'h3f, 6'h3f, 6'h3f, 6'h3f, 2'b11, 32'h0);
        vecs[1]  = mk(6'h2a, 6'h15, 6'h2a, 6'h15, 2'b01, 32'h0);
        vecs[2]  = mk(6'h00, 6'h00, 6'h00, 6'h02, 2'b00, {6'h01, 6'h00, 6'h00, 6'h00, 8'h00});
        vecs[3]  = mk(6'h00, 6'h00, 6'h00, 6'h01, 2'b00, {6'h00, 6'h00, 6'h00, 6'h00, 8'h01});
        vecs[4]  = mk(6'h3f, 6'h3f, 6'h3f, 6'h3f, 2'b11, {6'h01, 6'h00, 6'h00, 6'h00, 8'h01});
        vecs[5]  = mk(6'h3f, 6'h3f, 6'h3f, 6'h3d, 2'b11, {6'h00, 6'h00, 6'h00, 6'h00, 8'h01});
        vecs[6]  = mk(6'h00, 6'h01, 6'h00, 6'h00, 2'b00, {6'h01, 6'h00, 6'h00, 6'h00, 8'h00});
        vecs[7]  = mk(6'h00, 6'h20, 6'h05, 6'h00, 2'b00, {6'h06, 6'h22, 6'h00, 6'h14, 8'h06});
        vecs[8]  = mk(6'h21, 6'h00, 6'h00, 6'h31, 2'b10, {6'h28, 6'h00, 6'h31, 6'h00, 8'he8});
        vecs[9]  = mk(6'h3f, 6'h3f, 6'h3f, 6'h3f, 2'b11, {6'h3f, 6'h3f, 6'h3f, 6'h3f, 8'hef});
        vecs[10] = mk(6'h3f, 6'h3f, 6'h3f, 6'h3f, 2'b01, {6'h3f, 6'h3f, 6'h3f, 6'h3f, 8'hff});
        vecs[11] = mk(6'h3f, 6'h3f, 6'h3f, 6'h3f, 2'b10, 32'h0);

        pat = {8{32'hc3a5_96e1}};

        reset = 1'b1;
        config_in = 1'b0; config_valid = 1'b0; config_commit = 1'b0;
        drive(6'h0, 6'h0, 6'h0, 6'h0, 2'b00);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state: nothing routed before a commit.
        check("rst_cfg_out", {31'd0, config_out}, 32'd0);
        check("rst_loaded", {31'd0, config_loaded}, 32'd0);
        run_vectors(0, 1);

        // Config A: north0 <- west[1], le0_i0 <- west[0], everything else off.
        cfg_fill(3'd7, 5'd31);
        set_trk(0, 0, 3'd4);
        set_le(0, 0, 5'd2);
        load_cfg();
        commit();
        check("loaded_a", {31'd0, config_loaded}, 32'd1);
        run_vectors(2, 5);

        // Config B: a mix of LE, Wilton and LE-input selects.
        nsel = '{3'd2, 3'd2, 3'd3, 3'd1, 3'd0, 3'd4};
        lsel = '{5'd0, 5'd8, 5'd19, 5'd25, 5'd26, 5'd1, 5'd7, 5'd20};
        cfg_fill(3'd2, 5'd31);
        for (int i = 0; i < 6; i++) begin
            set_trk(0, i, nsel[i]);
            set_trk(3, i, 3'd4);
        end
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 4; j++)
                set_le(k, j, lsel[k*4+j]);
        load_cfg();
        commit();
        run_vectors(6, 9);

        // Chain latency: each bit reappears on config_out after c_cfg_bits shifts.
        for (int n = 0; n < c_cfg_bits + 8; n++) begin
            config_in    = pat[n];
            config_valid = 1'b1;
            @(posedge clock); #1;
            if (n >= c_cfg_bits - 1)
                check($sformatf("chain%0d", n - (c_cfg_bits - 1)), {31'd0, config_out},
                      {31'd0, pat[n-(c_cfg_bits-1)]});
        end
        config_valid = 1'b0;
        run_vectors(8, 8);

        // Commit in the same cycle as a shift: active takes config A, not its shifted copy.
        cfg_fill(3'd7, 5'd31);
        set_trk(0, 0, 3'd4);
        set_le(0, 0, 5'd2);
        load_cfg();
        config_in = 1'b0; config_valid = 1'b1; config_commit = 1'b1;
        @(posedge clock); #1;
        config_valid = 1'b0; config_commit = 1'b0;
        run_vectors(2, 3);

        // Reset mid-shift, with valid and commit also high, discards everything.
        for (int n = 0; n < 50; n++) begin
            config_in = 1'b1; config_valid = 1'b1;
            @(posedge clock); #1;
        end
        reset = 1'b1; config_commit = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; config_commit = 1'b0; config_valid = 1'b0; config_in = 1'b0;
        check("rst2_loaded", {31'd0, config_loaded}, 32'd0);
        check("rst2_cfg_out", {31'd0, config_out}, 32'd0);
        run_vectors(0, 0);
        for (int n = 0; n < c_cfg_bits - 50; n++) begin
            config_in = 1'b0; config_valid = 1'b1;
            @(posedge clock); #1;
        end
        config_valid = 1'b0;
        check("rst2_flush", {31'd0, config_out}, 32'd0);
        commit();
        check("rst2_loaded_after", {31'd0, config_loaded}, 32'd1);
        run_vectors(10, 11);

`ifdef SWITCHBOX_OUTPUT_REG_EN
        // east3 <- south[4], registered through its bypass bit.
        cfg_fill(3'd7, 5'd31);
        set_trk(1, 3, 3'd2);
        cfg[112 + 1*6 + 3] = 1'b1;
        load_cfg();
        commit();
        drive(6'h0, 6'h0, 6'h0, 6'h0, 2'b00);
        @(posedge clock); #1;
        data_south_in = 6'h10;
        #2 check("reg_hold0", {31'd0, data_east_out[3]}, 32'd0);
        @(posedge clock); #1;
        check("reg_rise", {31'd0, data_east_out[3]}, 32'd1);
        data_south_in = 6'h00;
        #2 check("reg_hold1", {31'd0, data_east_out[3]}, 32'd1);
        @(posedge clock); #1;
        check("reg_fall", {31'd0, data_east_out[3]}, 32'd0);

        // Same route with the bypass bit cleared: zero latency.
        cfg[112 + 1*6 + 3] = 1'b0;
        load_cfg();
        commit();
        data_south_in = 6'h10;
        #2 check("comb_rise", {31'd0, data_east_out[3]}, 32'd1);
        data_south_in = 6'h00;
        #2 check("comb_fall", {31'd0, data_east_out[3]}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/switchbox_cfg.md
# switchbox_cfg

Parametrised Wilton switch box that holds its own configuration. It generalises the fixed 6-track, 2-LE switch box to any channel width and LE count. It replaces the wide parallel configuration bus with a serial shadow/active configuration chain that can be daisy-chained between tiles. It sits in every logic tile between the four routing channels and the tile's LE inputs and outputs.

## Interface
- CHANNEL_WIDTH, 6, tracks per side (W), ≥2
- LE_COUNT, 2, LEs fed by this box (L); also the width of data_from_les
- LE_INPUTS, 4, inputs per LE (I)
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- data_{north,east,south,west}_in  in  W  incoming tracks per side
- data_{north,east,south,west}_out  out  W  outgoing tracks per side
- data_from_les  in  L  LE outputs
- data_to_les  out  L*I  LE inputs; LE k input j is bit k*I+j
- config_in  in  1  serial configuration bit
- config_valid  in  1  shift enable; shift one bit per cycle while high
- config_commit  in  1  copy shadow to active
- config_out  out  1  serial chain output, shadow MSB
- config_loaded  out  1  high once a commit has occurred since reset

## Operation
- Derived values:
  - SB_SEL = clog2(3+L)
  - LE_SEL = clog2(4W+L)
  - CFG_BITS = 4·W·SB_SEL + L·I·LE_SEL, plus 4·W when the output-register feature is compiled in
  - Defaults give 112.
- Field layout, LSB first:
  - Track selects: north 0..W-1, east, south, west.
  - Then LE selects, ordered le0_i0..le(L-1)_i(I-1).
  - Then the bypass bits, if present.
- Shift: when config_valid=1, shadow ← {shadow[CFG_BITS-2:0], config_in}. When config_valid=0, shadow holds.
  - After CFG_BITS shifts, the first bit shifted in sits at the MSB.
  - config_out = shadow[CFG_BITS-1].
- Commit: when config_commit=1, active ← shadow, using the pre-shift value, and config_loaded ← 1.
  - If config_valid and config_commit are high in the same cycle, the shift still occurs; active takes the old shadow.
- Until config_loaded=1, every side output and data_to_les bit is forced to 0. This prevents routing loops from a cleared configuration.
- Track mux, output track i: select s in 0..L-1 picks data_from_les[s]. Selects L, L+1 and L+2 pick the three Wilton sources below; any other select value gives 0.
  - north i: east[(W-i)%W], south[i], west[(i+1)%W]
  - east i: south[(i+1)%W], west[i], north[(W-i)%W]
  - south i: west[(2W-2-i)%W], north[i], east[(i+1)%W]
  - west i: north[(i+1)%W], east[i], south[(2W-2-i)%W]
- LE mux select s:
  - 0..L-1: data_from_les[s]
  - L..L+W-1: west[s-L]
  - then south, then east, then north, each W wide
  - s ≥ 4W+L: 0
- All arithmetic is unsigned. Indices are computed at elaboration; there are no runtime modulo operations.

## Timing
- Reset clears shadow, active and config_loaded; config_out=0; all data outputs 0.
  - Reset has priority over config_valid and config_commit in the same cycle.
- Reset mid-shift discards all partially shifted bits.
- Shift-chain latency: a bit on config_in appears on config_out CFG_BITS cycles later.
- Commit latency: the new routing is visible combinationally in the cycle after the commit edge.
- Data path is purely combinational from data_*_in / data_from_les to the outputs, unless the output-register feature below is compiled in.
- No back-pressure: config_valid is a strobe, not a handshake. The loader counts CFG_BITS itself.

## Configuration
- SWITCHBOX_OUTPUT_REG_EN
  - Defined: each of the 4·W side output tracks has a flop plus one active config bypass bit.
    - bit=1: the output is registered, one cycle of latency; flop resets to 0.
    - bit=0: the output is combinational.
    - CFG_BITS grows by 4·W.
    - data_to_les is never registered.
  - Undefined: no flops on the data path, no bypass bits, defaults give CFG_BITS=112.

## Structure
- switchbox_pkg holds:
  - clog2-based functions for SB_SEL, LE_SEL and CFG_BITS
  - Wilton source index functions (side, track, W) → index
  - field offset functions
- Sub-module switchbox_mux(N): N-input, clog2(N)-select mux, with out-of-range select giving 0. It is used for both track and LE muxes.

## Test plan
All cases use W=6, L=2, I=4 unless stated.
- Reset, no commit, toggle all inputs → all outputs 0, config_loaded=0.
- Configure north0 select=4 (west[1]), all other selects 7, then commit. Set west_in=6'b000010 → north_out[0]=1, every other side output 0, config_loaded=1.
- Configure le0_i0 select=2 and le1_i3 select=31, then commit. Set west_in[0]=1 → data_to_les[0]=1 and data_to_les[7]=0.
- Shift 112 bits of a known pattern followed by 8 more bits → config_out replays the first 8 bits on cycles 113–120.
- Assert commit together with config_valid → active matches the pre-shift shadow. Assert reset after 50 shifts → config_out=0 and a later commit yields all-zero routing.
- With SWITCHBOX_OUTPUT_REG_EN defined, bypass=1 on east3 → east_out[3] follows its source with exactly one cycle of delay. With bypass=0 it has zero delay.
